arbitro_memoria_dados: RTL

Two-port arbiter that shares the single-port data memory between the RISC-V datapath's load/store port and a program/data loader port. The loader port is used for memory initialisation and debug. It sits between the datapath and the data memory. It grants at most one access per cycle, returns read data one cycle later, and raises a stall to the datapath when the core's request is not granted. Misaligned word accesses are blocked and flagged.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/seletor_round_robin.sv | 50 +++++
 rtl/arbitro_memoria_dados.sv | 94 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V memory-subsystem definitions: requester IDs and the
// pending-read tag carried from a granted load to its data return.
package riscv_pkg;

    localparam logic ID_NUCLEO     = 1'b0;
    localparam logic ID_CARREGADOR = 1'b1;

    // Tag for a load in flight: who asked and whether it was blocked.
    typedef struct packed {
        logic valid;
        logic id;
        logic desalinhado;
    } tag_pendente_t;

endpackage

// File: rtl/seletor_round_robin.sv
// Two-input grant generator. req[0]/gnt[0] is the higher-default requester
// (core), req[1]/gnt[1] the other (loader).
// Build option ARBITRO_PRIORIDADE_FIXA_EN: requester 0 always wins and no
// priority register exists; otherwise a round-robin pointer alternates wins.
module seletor_round_robin (
`ifndef ARBITRO_PRIORIDADE_FIXA_EN
    input  logic       clk,
`endif
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef ARBITRO_PRIORIDADE_FIXA_EN

    // Fixed priority: requester 1 only when requester 0 is silent.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            gnt[0] = req[0];
            gnt[1] = req[1] & ~req[0];
        end
    end

`else

    logic prio;  // 0 = requester 0 first, 1 = requester 1 first

    // Round-robin grant; no grants while reset is held.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            if (req == 2'b11)
                gnt = prio ? 2'b10 : 2'b01;
            else
                gnt = req;
        end
    end

    // After any grant, favour the requester that did not win.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prio <= 1'b0;
        else if (|gnt)
            prio <= gnt[0];
    end

`endif

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Data-memory arbiter between the core load/store port and the loader port.
// One access granted per cycle, read data returned the following cycle,
// misaligned word accesses blocked and flagged.
// Build option ARBITRO_PRIORIDADE_FIXA_EN: core always wins on contention.
module arbitro_memoria_dados
    import riscv_pkg::*;
#(
    parameter int LARGURA_END  = 32,
    parameter int LARGURA_DADO = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    nucleo_req,
    input  logic                    nucleo_we,
    input  logic [LARGURA_END-1:0]  nucleo_end,
    input  logic [LARGURA_DADO-1:0] nucleo_wdata,
    output logic                    nucleo_gnt,
    output logic                    nucleo_rvalid,
    output logic [LARGURA_DADO-1:0] nucleo_rdata,
    output logic                    nucleo_stall,
    input  logic                    carr_req,
    input  logic                    carr_we,
    input  logic [LARGURA_END-1:0]  carr_end,
    input  logic [LARGURA_DADO-1:0] carr_wdata,
    output logic                    carr_gnt,
    output logic                    carr_rvalid,
    output logic [LARGURA_DADO-1:0] carr_rdata,
    output logic                    erro_alinhamento,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [LARGURA_END-1:0]  mem_end,
    output logic [LARGURA_DADO-1:0] mem_wdata,
    input  logic [LARGURA_DADO-1:0] mem_rdata
);

    logic [1:0]              gnt;
    logic                    garantido;
    logic                    sel_we;
    logic [LARGURA_END-1:0]  sel_end;
    logic [LARGURA_DADO-1:0] sel_wdata;
    logic                    desal;
    tag_pendente_t           pend;
    logic                    erro_q;

    seletor_round_robin u_seletor (
`ifndef ARBITRO_PRIORIDADE_FIXA_EN
        .clk   (clk),
`endif
        .reset (reset),
        .req   ({carr_req, nucleo_req}),
        .gnt   (gnt)
    );

    assign nucleo_gnt   = gnt[0];
    assign carr_gnt     = gnt[1];
    assign garantido    = |gnt;
    assign nucleo_stall = nucleo_req & ~gnt[0] & ~reset;

    // Winner payload mux and memory drive; misaligned or idle leaves memory quiet.
    always_comb begin
        sel_we    = gnt[1] ? carr_we    : nucleo_we;
        sel_end   = gnt[1] ? carr_end   : nucleo_end;
        sel_wdata = gnt[1] ? carr_wdata : nucleo_wdata;
        desal     = |sel_end[1:0];
        mem_en    = garantido & ~desal;
        mem_we    = mem_en & sel_we;
        mem_end   = mem_en ? sel_end   : '0;
        mem_wdata = mem_en ? sel_wdata : '0;
    end

    // Capture the pending-load tag and the alignment error for next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend   <= '0;
            erro_q <= 1'b0;
        end else begin
            pend.valid       <= garantido & ~sel_we;
            pend.id          <= gnt[1] ? ID_CARREGADOR : ID_NUCLEO;
            pend.desalinhado <= desal;
            erro_q           <= garantido & desal;
        end
    end

    // Route returning data to the owner only; blocked loads return zero.
    always_comb begin
        nucleo_rvalid = pend.valid & (pend.id == ID_NUCLEO);
        carr_rvalid   = pend.valid & (pend.id == ID_CARREGADOR);
        nucleo_rdata  = (nucleo_rvalid && !pend.desalinhado) ? mem_rdata : '0;
        carr_rdata    = (carr_rvalid   && !pend.desalinhado) ? mem_rdata : '0;
    end

    assign erro_alinhamento = erro_q;

endmodule
